// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Each line holds 4 words. Tag and data live in inferred block RAM with
// registered reads; valid bits are flops so reset can clear them at once.
module data_cache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [29:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_FILL,
        WR_REQ,
        RESPOND
    } state_t;

    // Control state
    state_t            state_q, state_d;
    logic              lookup_q, lookup_d;   // a read was accepted last edge
    logic [1:0]        beat_q, beat_d;
    logic [31:0]       resp_word_q, resp_word_d;
    logic [LINES-1:0]  valid_q, valid_d;

    // Captured request
    logic [29:0]       addr_q;
    logic [3:0]        we_q;
    logic [31:0]       din_q;

    // Registered RAM read results for the captured request
    logic              rd_valid_q;
    logic [TW-1:0]     rd_tag_q;
    logic [31:0]       rd_data_q;

    // Storage arrays
    logic [TW-1:0]     tag_mem  [LINES];
    logic [31:0]       data_mem [LINES*4];

    // RAM write port controls
    logic              ram_we;
    logic [IW+1:0]     ram_waddr;
    logic [31:0]       ram_wdata;
    logic              tag_we;
    logic              accept;

    logic [TW-1:0]     req_tag;
    logic [IW-1:0]     req_idx;
    logic [1:0]        req_off;
    logic              hit;
    logic [31:0]       merged_word;
    logic              unused_addr_bits;

    assign req_tag = addr_q[29:IW+2];
    assign req_idx = addr_q[IW+1:2];
    assign req_off = addr_q[1:0];
    assign hit     = rd_valid_q && (rd_tag_q == req_tag);

    // Only bits [29:0] of the CPU address carry meaning.
    assign unused_addr_bits = ^dcache_addr[31:30];

    // Byte-merge store data into the old word for write hits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[gi*8 +: 8] = we_q[gi] ? din_q[gi*8 +: 8]
                                                     : rd_data_q[gi*8 +: 8];
        end
    endgenerate

    // Next-state, memory-request and CPU-facing outputs.
    always_comb begin
        state_d       = state_q;
        lookup_d      = 1'b0;
        beat_d        = beat_q;
        resp_word_d   = resp_word_q;
        valid_d       = valid_q;
        stall         = 1'b0;
        dcache_dout   = 32'd0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 30'd0;
        mem_req_data  = 32'd0;
        mem_req_mask  = 4'd0;
        ram_we        = 1'b0;
        ram_waddr     = {req_idx, beat_q};
        ram_wdata     = mem_resp_data;
        tag_we        = 1'b0;
        accept        = 1'b0;

        case (state_q)
            IDLE: begin
                if (lookup_q) begin
                    if (hit) begin
                        dcache_dout = rd_data_q;
                    end else begin
                        stall   = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[29:2], 2'b00};
                if (mem_req_ready) begin
                    // Line is invalid from here until the last beat lands,
                    // so an abandoned fill never leaves a half-written line.
                    valid_d[req_idx] = 1'b0;
                    beat_d           = 2'd0;
                    state_d          = RD_FILL;
                end
            end
            RD_FILL: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    ram_we = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == req_off) begin
                        resp_word_d = mem_resp_data;
                    end
                    if (beat_q == 2'd3) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        state_d          = RESPOND;
                    end
                end
            end
            WR_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = addr_q;
                mem_req_data  = din_q;
                mem_req_mask  = we_q;
                if (mem_req_ready) begin
                    state_d = RESPOND;
                    if (hit) begin
                        ram_we    = 1'b1;
                        ram_waddr = addr_q[IW+1:0];
                        ram_wdata = merged_word;
                    end
                end
            end
            RESPOND: begin
                dcache_dout = resp_word_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new CPU request is taken on any non-stalled cycle.
        if (!stall && (dcache_re || (dcache_we != 4'd0))) begin
            accept = 1'b1;
            if (dcache_we != 4'd0) begin
                state_d = WR_REQ;
            end else begin
                state_d  = IDLE;
                lookup_d = 1'b1;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lookup_q    <= 1'b0;
            beat_q      <= 2'd0;
            resp_word_q <= 32'd0;
            valid_q     <= '0;
            addr_q      <= 30'd0;
            we_q        <= 4'd0;
            din_q       <= 32'd0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lookup_q    <= lookup_d;
            beat_q      <= beat_d;
            resp_word_q <= resp_word_d;
            valid_q     <= valid_d;
            if (accept) begin
                addr_q     <= dcache_addr[29:0];
                we_q       <= dcache_we;
                din_q      <= dcache_din;
                rd_valid_q <= valid_q[dcache_addr[IW+1:2]];
            end
        end
    end

    // Tag/data RAMs: single write port, registered read at request accept.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            data_mem[ram_waddr] <= ram_wdata;
        end
        if (tag_we && !reset) begin
            tag_mem[req_idx] <= req_tag;
        end
        if (accept) begin
            rd_data_q <= data_mem[dcache_addr[IW+1:0]];
            rd_tag_q  <= tag_mem[dcache_addr[IW+1:2]];
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed, table-driven bench for data_cache with a small backing memory.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
        bit          exp_mem;
        logic [29:0] exp_maddr;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[14];

    // Backing memory: written words are stored, others follow a fixed pattern.
    logic [31:0] bmem [logic [29:0]];

    data_cache #(.LINES(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .dcache_addr   (dcache_addr),
        .dcache_re     (dcache_re),
        .dcache_we     (dcache_we),
        .dcache_din    (dcache_din),
        .dcache_dout   (dcache_dout),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_mask  (mem_req_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic mem_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        bmem[a] = w;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input bit wr, input logic [31:0] addr,
                                input logic [3:0] we, input logic [31:0] din, input bit exp_mem,
                                input logic [29:0] exp_maddr, input logic [31:0] exp_dout);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = addr; v.we = we; v.din = din;
        v.exp_mem = exp_mem; v.exp_maddr = exp_maddr; v.exp_dout = exp_dout;
        return v;
    endfunction

    // One CPU transaction, acting as the backing memory while stalled.
    task automatic do_txn(input vec_t v);
        bit          done = 0;
        bit          seen = 0;
        bit          handshook = 0;
        int          beat = 0;
        logic        cap_rw = 1'b0;
        logic [29:0] cap_addr = '0;
        logic [31:0] cap_data = '0;
        logic [3:0]  cap_mask = '0;
        logic [31:0] cap_dout = '0;

        @(negedge clk);
        dcache_addr = v.addr;
        dcache_din  = v.din;
        if (v.wr) begin
            dcache_we = v.we;
            dcache_re = 1'b0;
        end else begin
            dcache_we = 4'd0;
            dcache_re = 1'b1;
        end

        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (!stall) begin
                done      = 1;
                cap_dout  = dcache_dout;
                dcache_re = 1'b0;
                dcache_we = 4'd0;
            end else if (mem_req_valid && !handshook) begin
                if (!seen) begin
                    seen     = 1;
                    cap_rw   = mem_req_rw;
                    cap_addr = mem_req_addr;
                    cap_data = mem_req_data;
                    cap_mask = mem_req_mask;
                end else begin
                    check({v.name, " hold_addr"}, {2'b00, mem_req_addr}, {2'b00, cap_addr});
                    check({v.name, " hold_rw"}, {31'd0, mem_req_rw}, {31'd0, cap_rw});
                    check({v.name, " hold_data"}, mem_req_data, cap_data);
                    mem_req_ready  = 1'b1;
                    handshook      = 1;
                    // Stray beat alongside ready must be ignored by the cache.
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = 32'hBAD0BAD0;
                    if (cap_rw) mem_wr(cap_addr, cap_data, cap_mask);
                end
            end else if (handshook && !cap_rw && beat < 4) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_rd({cap_addr[29:2], beat[1:0]});
                beat++;
            end
        end

        check({v.name, " completed"}, {31'd0, done}, 32'd1);
        check({v.name, " mem_req_seen"}, {31'd0, seen}, {31'd0, v.exp_mem});
        if (seen && v.exp_mem) begin
            check({v.name, " req_rw"}, {31'd0, cap_rw}, {31'd0, v.wr});
            check({v.name, " req_addr"}, {2'b00, cap_addr}, {2'b00, v.exp_maddr});
            if (v.wr) begin
                check({v.name, " req_data"}, cap_data, v.din);
                check({v.name, " req_mask"}, {28'd0, cap_mask}, {28'd0, v.we});
            end
        end
        if (!v.wr) check({v.name, " dout"}, cap_dout, v.exp_dout);
        $display("txn %-12s %s addr=%h mem=%0d dout=%h", v.name, v.wr ? "WR" : "RD",
                 v.addr, seen, cap_dout);
    endtask

    // Reset asserted while the third fill beat is on the bus.
    task automatic reset_mid_fill();
        bit got = 0;
        @(negedge clk);
        dcache_addr = 32'h210;
        dcache_re   = 1'b1;
        dcache_we   = 4'd0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = mem_req_valid;
        end
        check("rst_fill req_seen", {31'd0, got}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_rd(30'h210);
        @(negedge clk);
        mem_resp_data  = mem_rd(30'h211);
        @(negedge clk);
        mem_resp_data  = mem_rd(30'h212);
        reset          = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        dcache_re      = 1'b0;
        check("rst_fill stall", {31'd0, stall}, 32'd0);
        check("rst_fill mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_fill dout", dcache_dout, 32'd0);
        mem_resp_data  = mem_rd(30'h213);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("rst_fill late_beat stall", {31'd0, stall}, 32'd0);
        $display("txn rst_fill     reset applied during fill beat 2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("rd10_miss",   0, 32'h010,      4'h0, 32'h0,        1, 30'h010, 32'hC3B50010);
        vecs[1]  = mk("rd13_hit",    0, 32'h013,      4'h0, 32'h0,        0, 30'h0,   32'hC3B60013);
        vecs[2]  = mk("wr11_hit",    1, 32'h011,      4'h3, 32'hDEADBEEF, 1, 30'h011, 32'h0);
        vecs[3]  = mk("rd11_merged", 0, 32'h011,      4'h0, 32'h0,        0, 30'h0,   32'hC3B4BEEF);
        vecs[4]  = mk("wr400_miss",  1, 32'h400,      4'hF, 32'h12345678, 1, 30'h400, 32'h0);
        vecs[5]  = mk("rd400_miss",  0, 32'h400,      4'h0, 32'h0,        1, 30'h400, 32'h12345678);
        vecs[6]  = mk("rd110_evict", 0, 32'h110,      4'h0, 32'h0,        1, 30'h110, 32'hC2B50110);
        vecs[7]  = mk("rd10_again",  0, 32'h010,      4'h0, 32'h0,        1, 30'h010, 32'hC3B50010);
        vecs[8]  = mk("rd11_refill", 0, 32'h011,      4'h0, 32'h0,        0, 30'h0,   32'hC3B4BEEF);
        vecs[9]  = mk("wr12_hi",     1, 32'h012,      4'hC, 32'h55667788, 1, 30'h012, 32'h0);
        vecs[10] = mk("rd12_merged", 0, 32'h012,      4'h0, 32'h0,        0, 30'h0,   32'h55660012);
        vecs[11] = mk("rd402_hit",   0, 32'h402,      4'h0, 32'h0,        0, 30'h0,   32'hC7A70402);
        vecs[12] = mk("rd3_conflict",0, 32'h003,      4'h0, 32'h0,        1, 30'h000, 32'hC3A60003);
        vecs[13] = mk("rd13_hibits", 0, 32'hC0000013, 4'h0, 32'h0,        0, 30'h0,   32'hC3B60013);

        reset          = 1'b1;
        dcache_addr    = 32'd0;
        dcache_re      = 1'b0;
        dcache_we      = 4'd0;
        dcache_din     = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("reset dout", dcache_dout, 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_txn(vecs[i]);
        end

        reset_mid_fill();
        do_txn(mk("rd10_postrst", 0, 32'h010, 4'h0, 32'h0, 1, 30'h010, 32'hC3B50010));
        do_txn(mk("rd210_retry",  0, 32'h210, 4'h0, 32'h0, 1, 30'h210, 32'hC1B50210));
        do_txn(mk("rd213_hit",    0, 32'h213, 4'h0, 32'h0, 0, 30'h0,   32'hC1B60213));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
